// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display driver.
//   NUM_DIGITS : number of multiplexed digits
//   VALUE_MAX  : largest displayable value; larger inputs saturate to it
//   SEG_BLANK  : active-low segment pattern with every segment off
//   font()     : BCD digit to active-low {g,f,e,d,c,b,a} pattern
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [13:0] VALUE_MAX  = 14'd9999;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } conv_state_e;

  // Non-decimal nibbles cannot come out of the converter; show them blank.
  function automatic logic [6:0] font(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running sequential double-dabble converter, 16 cycles per conversion.
//   clk_in : clock
//   rst    : synchronous active-high reset
//   bin    : binary input, sampled (and saturated) in the idle cycle
//   bcd    : BCD accumulator; holds the finished result while done is high
//   done   : one-cycle pulse when bcd holds a completed conversion
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        done
);

  conv_state_e r_state, w_state_nx;
  logic [3:0]  r_iter, w_iter_nx;
  logic [13:0] r_bin, w_bin_nx;
  logic [15:0] r_bcd, w_bcd_nx;
  logic [15:0] w_bcd_adj;
  logic [13:0] w_bin_sat;

  assign w_bin_sat = (bin > VALUE_MAX) ? VALUE_MAX : bin;

  // Add-3 correction applied before every shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < 4; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_iter_nx  = r_iter;
    w_bin_nx   = r_bin;
    w_bcd_nx   = r_bcd;
    done       = 1'b0;
    case (r_state)
      StIdle: begin
        w_bin_nx   = w_bin_sat;
        w_bcd_nx   = '0;
        w_iter_nx  = '0;
        w_state_nx = StShift;
      end
      StShift: begin
        {w_bcd_nx, w_bin_nx} = {w_bcd_adj[14:0], r_bin, 1'b0};
        if (r_iter == 4'd13) begin
          w_iter_nx  = '0;
          w_state_nx = StDone;
        end else begin
          w_iter_nx = r_iter + 4'd1;
        end
      end
      StDone: begin
        done       = 1'b1;
        w_state_nx = StIdle;
      end
      default: w_state_nx = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= StIdle;
      r_iter  <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_iter  <= w_iter_nx;
      r_bin   <= w_bin_nx;
      r_bcd   <= w_bcd_nx;
    end
  end

  assign bcd = r_bcd;

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with background BCD conversion.
//   clk_in  : 1 kHz clock            rst     : synchronous active-high reset
//   value   : binary value to show   blank   : 1 = all anodes off
//   blink   : 1 = gate by blink phase
//   dp_mask : per-digit decimal point enable (bit 0 = rightmost)
//   an      : active-low anodes      seg     : active-low {g,f,e,d,c,b,a}
//   dp      : active-low decimal point
module seg7_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned BLINK_HALF_PERIOD  = 250,
  parameter bit          LEADING_ZERO_BLANK = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        blank,
  input  logic        blink,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned BlinkW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF_PERIOD - 1);

  logic [1:0]        r_idx;
  logic [BlinkW-1:0] r_blink_cnt;
  logic              r_phase;
  logic [15:0]       r_disp_bcd;
  logic [3:0]        r_an;
  logic [6:0]        r_seg;
  logic              r_dp;

  logic [15:0] w_bcd;
  logic        w_done;
  logic [3:0]  w_upper_zero;
  logic [3:0]  w_nib;
  logic        w_digit_en;

  bin2bcd_seq u_conv (
    .clk_in (clk_in),
    .rst    (rst),
    .bin    (value),
    .bcd    (w_bcd),
    .done   (w_done)
  );

  // w_upper_zero[k]: nibbles k..3 of the displayed value are all zero.
  always_comb begin
    w_upper_zero    = '0;
    w_upper_zero[3] = (r_disp_bcd[15:12] == 4'd0);
    w_upper_zero[2] = w_upper_zero[3] && (r_disp_bcd[11:8] == 4'd0);
    w_upper_zero[1] = w_upper_zero[2] && (r_disp_bcd[7:4] == 4'd0);
    w_upper_zero[0] = w_upper_zero[1] && (r_disp_bcd[3:0] == 4'd0);
    w_nib           = r_disp_bcd[{r_idx, 2'b00} +: 4];
    w_digit_en      = !blank && (!blink || r_phase) &&
                      !(LEADING_ZERO_BLANK && (r_idx != 2'd0) && w_upper_zero[r_idx]);
  end

  // Outputs use the pre-edge r_disp_bcd, so a same-edge update shows next scan.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_idx       <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
      r_disp_bcd  <= '0;
      r_an        <= 4'hF;
      r_seg       <= SEG_BLANK;
      r_dp        <= 1'b1;
    end else begin
      r_idx <= r_idx + 2'd1;
      if (r_blink_cnt == BlinkLast) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BlinkW'(1);
      end
      if (w_done) begin
        r_disp_bcd <= w_bcd;
      end
      if (w_digit_en) begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= font(w_nib);
        r_dp  <= ~dp_mask[r_idx];
      end else begin
        r_an  <= 4'hF;
        r_seg <= SEG_BLANK;
        r_dp  <= 1'b1;
      end
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [13:0] value;
  logic        blank;
  logic        blink;
  logic [3:0]  dp_mask;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: edges since reset release, latched sample, displayed value.
  int  m_edge   = 0;
  int  m_sample = 0;
  int  m_disp   = 0;
  bit  m_valid  = 1'b0;

  logic [3:0] ea_an, eb_an;
  logic [6:0] ea_seg, eb_seg;
  logic       ea_dp, eb_dp;

  always #5 clk_in = ~clk_in;

  seg7_scan_driver #(.BLINK_HALF_PERIOD(4), .LEADING_ZERO_BLANK(1'b1)) dut_a (
    .clk_in(clk_in), .rst(rst), .value(value), .blank(blank), .blink(blink),
    .dp_mask(dp_mask), .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  seg7_scan_driver #(.BLINK_HALF_PERIOD(250), .LEADING_ZERO_BLANK(1'b0)) dut_b (
    .clk_in(clk_in), .rst(rst), .value(value), .blank(blank), .blink(blink),
    .dp_mask(dp_mask), .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  function automatic logic [6:0] digit_font(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  // Decimal-level view: digit k of the shown number, blanking rules applied.
  task automatic model_out(input int disp, input int e, input int half, input bit lzb,
                           input bit bl, input bit bk, input logic [3:0] dpm,
                           output logic [3:0] o_an, output logic [6:0] o_seg,
                           output logic o_dp);
    int k;
    int pw;
    bit vis;
    k  = e % 4;
    pw = 1;
    for (int i = 0; i < k; i++) pw = pw * 10;
    vis = !bl && (!bk || ((e / half) % 2 == 0)) && !(lzb && k > 0 && disp < pw);
    if (vis) begin
      o_an  = 4'hF & ~(4'd1 << k);
      o_seg = digit_font((disp / pw) % 10);
      o_dp  = ~dpm[k];
    end else begin
      o_an  = 4'hF;
      o_seg = 7'h7F;
      o_dp  = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(posedge clk_in) begin
    if (rst) begin
      ea_an = 4'hF; ea_seg = 7'h7F; ea_dp = 1'b1;
      eb_an = 4'hF; eb_seg = 7'h7F; eb_dp = 1'b1;
      m_edge = 0; m_sample = 0; m_disp = 0; m_valid = 1'b1;
      #1;
      chk("rst_an_a", an_a, ea_an);   chk("rst_seg_a", seg_a, ea_seg); chk("rst_dp_a", dp_a, ea_dp);
      chk("rst_an_b", an_b, eb_an);   chk("rst_seg_b", seg_b, eb_seg); chk("rst_dp_b", dp_b, eb_dp);
    end else if (m_valid) begin
      model_out(m_disp, m_edge, 4, 1'b1, blank, blink, dp_mask, ea_an, ea_seg, ea_dp);
      model_out(m_disp, m_edge, 250, 1'b0, blank, blink, dp_mask, eb_an, eb_seg, eb_dp);
      if (m_edge % 16 == 0) m_sample = (int'(value) > 9999) ? 9999 : int'(value);
      if (m_edge % 16 == 15) m_disp = m_sample;
      m_edge++;
      #1;
      chk("model_an_a", an_a, ea_an);   chk("model_seg_a", seg_a, ea_seg);
      chk("model_dp_a", dp_a, ea_dp);   chk("model_an_b", an_b, eb_an);
      chk("model_seg_b", seg_b, eb_seg); chk("model_dp_b", dp_b, eb_dp);
    end
  end

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic align(input int modulus);
    while (m_edge % modulus != 0) step();
  endtask

  logic [3:0] scan_an [4];
  logic [6:0] exp_seg [4];

  initial begin
    scan_an = '{4'hE, 4'hD, 4'hB, 4'h7};
    rst = 1'b1; value = '0; blank = 1'b0; blink = 1'b0; dp_mask = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;

    // First scan after reset, displayed value 0.
    step(); chk("p0_an_a", an_a, 4'hE); chk("p0_seg_a", seg_a, 7'h40); chk("p0_dp_a", dp_a, 1'b1);
            chk("p0_an_b", an_b, 4'hE); chk("p0_seg_b", seg_b, 7'h40);
    step(); chk("p1_an_a", an_a, 4'hF); chk("p1_seg_a", seg_a, 7'h7F);
            chk("p1_an_b", an_b, 4'hD); chk("p1_seg_b", seg_b, 7'h40);
    step(); chk("p2_an_a", an_a, 4'hF); chk("p2_an_b", an_b, 4'hB);
    step(); chk("p3_an_a", an_a, 4'hF); chk("p3_an_b", an_b, 4'h7);

    // 1234 with decimal point on digit 2.
    value = 14'd1234; dp_mask = 4'b0100;
    repeat (32) step();
    align(4);
    exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    for (int k = 0; k < 4; k++) begin
      step();
      chk("v1234_an", an_a, scan_an[k]);
      chk("v1234_seg", seg_a, exp_seg[k]);
      chk("v1234_dp", dp_a, (k == 2) ? 1'b0 : 1'b1);
    end

    // Saturation.
    value = 14'd12000; dp_mask = 4'b0000;
    repeat (32) step();
    align(4);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("sat_seg_a", seg_a, 7'h10);
      chk("sat_seg_b", seg_b, 7'h10);
    end

    // Blink with half period 4 on instance A.
    blink = 1'b1;
    align(8);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("blink_an_a", an_a, (k < 4) ? scan_an[k] : 4'hF);
    end
    blink = 1'b0; blank = 1'b1;
    step(); chk("blank_an_a", an_a, 4'hF); chk("blank_an_b", an_b, 4'hF);
            chk("blank_seg_a", seg_a, 7'h7F);
    blank = 1'b0;

    // Value 1: no zero suppression on B, suppression on A.
    value = 14'd1;
    repeat (32) step();
    align(4);
    exp_seg = '{7'h79, 7'h40, 7'h40, 7'h40};
    for (int k = 0; k < 4; k++) begin
      step();
      chk("one_an_b", an_b, scan_an[k]);
      chk("one_seg_b", seg_b, exp_seg[k]);
      chk("one_an_a", an_a, (k == 0) ? 4'hE : 4'hF);
    end

    // Value changing every cycle; only the idle sample matters.
    for (int k = 0; k < 64; k++) begin
      value = 14'($urandom_range(0, 16383));
      step();
    end

    // Cross into the dark half of B's 250-cycle blink.
    value = 14'd4321; blink = 1'b1;
    while (m_edge < 252) step();
    chk("blink_dark_b", an_b, 4'hF);
    blink = 1'b0;

    // Reset in the middle of a conversion.
    value = 14'd5678;
    repeat (20) step();
    while (m_edge % 16 != 5) step();
    rst = 1'b1;
    step(); chk("mid_rst_an_a", an_a, 4'hF); chk("mid_rst_seg_b", seg_b, 7'h7F);
            chk("mid_rst_dp_b", dp_b, 1'b1);
    rst = 1'b0;
    step(); chk("rel_an_a", an_a, 4'hE); chk("rel_seg_a", seg_a, 7'h40);
    repeat (15) step();
    chk("pre_done_an_a", an_a, 4'hF); chk("pre_done_seg_b", seg_b, 7'h40);
    step(); chk("post_done_an_a", an_a, 4'hE); chk("post_done_seg_a", seg_a, 7'h00);
            chk("post_done_seg_b", seg_b, 7'h00);
    step(); chk("d1_seg_a", seg_a, 7'h78);
    step(); chk("d2_seg_a", seg_a, 7'h02);
    step(); chk("d3_seg_a", seg_a, 7'h12);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
